truth_table_scan: RTL and testbench
===================================

TRUTH_TABLE_SCAN -- requirements
Module: truth_table_scan

Interface
REQ-001 The block SHALL have parameter SETTLE, default 1, meaning the number of wait cycles between driving a minterm and sampling s; legal range 0..15.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit: scan request, sampled on clk.
REQ-005 The block SHALL have port s, input, 1 bit: output of the downstream 4-input combinational function under scan.
REQ-006 The block SHALL have port expected, input, 16 bits: golden truth table, bit i = required s at minterm i.
REQ-007 The block SHALL have ports a, b, c, d, each output, 1 bit: drive to the function inputs; minterm index = {a,b,c,d}, a is the MSB.
REQ-008 The block SHALL have port busy, output, 1 bit: a scan is in progress.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle pulse marking scan completion.
REQ-010 The block SHALL have port table, output, 16 bits: captured truth table, bit i = s sampled at minterm i.
REQ-011 The block SHALL have port ones, output, 5 bits: count of 1s in table, 0..16.
REQ-012 The block SHALL have port match, output, 1 bit: table equals expected at the end of the last scan.

Function
REQ-013 The FSM SHALL have states IDLE, WAIT, SAMPLE and DONE.
REQ-014 IDLE: start=1 SHALL set idx=0, clear table, ones and match, and go to WAIT, or directly to SAMPLE when SETTLE=0.
REQ-015 WAIT SHALL hold idx for exactly SETTLE cycles, then go to SAMPLE.
REQ-016 SAMPLE SHALL, on its closing edge, write table[idx]<=s and ones<=ones+s.
REQ-017 From SAMPLE, idx<15 SHALL give idx+1 and WAIT (or SAMPLE when SETTLE=0); idx=15 SHALL go to DONE.
REQ-018 DONE SHALL last one cycle with done=1 and match=(table==expected) registered, then go to IDLE.
REQ-019 {a,b,c,d} SHALL equal idx in WAIT and SAMPLE, and SHALL be 0000 in IDLE and DONE.
REQ-020 busy SHALL be 1 exactly in WAIT and SAMPLE.
REQ-021 Latency: start accepted at edge E0 SHALL produce done=1 in the cycle following edge E0+16*(SETTLE+1); with SETTLE=1, that is 32 edges.
REQ-022 start SHALL be ignored in WAIT, SAMPLE and DONE; a start held high through DONE SHALL be accepted in the following IDLE cycle.
REQ-023 table, ones and match SHALL hold their values in IDLE until the next accepted start.
REQ-024 idx SHALL NOT wrap past 15; scan termination SHALL rely only on idx=15 in SAMPLE.
REQ-025 ones SHALL be 5 bits wide so that a value of 16 (all-ones table) does not overflow.
REQ-026 expected SHALL be compared only in DONE; changes to expected at other times SHALL NOT affect match.

Reset
REQ-027 rst_n=0 SHALL immediately force state=IDLE, idx=0, settle count=0, a=b=c=d=0, busy=0, done=0, table=0, ones=0 and match=0, regardless of clock.
REQ-028 Reset asserted mid-scan SHALL abort the scan with no done pulse; after release, the block SHALL wait for a new start.

Structure
REQ-029 A shared package SHALL hold the state enum (IDLE, WAIT, SAMPLE, DONE), N_MINTERMS=16 and IDX_W=4.
REQ-030 The block SHALL contain one sub-module, scan_counter, holding the 4-bit idx and the settle counter and providing settle_done and last_idx flags; the FSM and capture logic SHALL stay in truth_table_scan.

Verification
REQ-031 Scenario 1: connect s=(~a&b&c&d)|(a&~c&d)|(a&c&~d)|(a&d&~b), SETTLE=1, expected=16'h6E80, pulse start -> table=16'h6E80, ones=6, match=1, done exactly 32 edges after start.
REQ-032 Scenario 2: same function, expected=16'h6E81 -> match=0, table=16'h6E80.
REQ-033 Scenario 3: s tied to 1, SETTLE=0 -> table=16'hFFFF, ones=16 (no overflow), done 16 edges after start; then s tied to 0 with a second start -> table=16'h0000, ones=0.
REQ-034 Scenario 4: pulse start again while busy=1 at minterm 5 -> the scan continues unchanged, with exactly one done pulse.
REQ-035 Scenario 5: assert rst_n=0 at minterm 9 -> all outputs 0 immediately with no done; a new start then yields a full correct scan.
REQ-036 Scenario 6: hold start high continuously with SETTLE=2 -> back-to-back scans, each done 48 edges after acceptance, with one idle cycle between scans and {a,b,c,d} stepping 0..15 in order each scan.

Source files
------------

// File: rtl/truth_table_scan_pkg.sv
// Shared types and sizes for the truth-table scanner.
package truth_table_scan_pkg;

   localparam int unsigned N_MINTERMS = 16;
   localparam int unsigned IDX_W      = 4;
   localparam int unsigned ONES_W     = 5;
   localparam int unsigned SETTLE_W   = 4;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      SAMPLE,
      DONE
   } state_t;

endpackage

// File: rtl/scan_counter.sv
// Minterm index and settle-delay counter for the truth-table scanner.
module scan_counter
   import truth_table_scan_pkg::*;
#(
   parameter int unsigned SETTLE = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             adv,
   input  logic             tick,
   output logic [IDX_W-1:0] idx,
   output logic             settle_done,
   output logic             last_idx
);

   localparam int unsigned CMP_W = SETTLE_W + 1;

   logic [SETTLE_W-1:0] settle_cnt;

   // High on the final WAIT cycle of the settle interval
   assign settle_done = (CMP_W'(settle_cnt) + CMP_W'(1)) >= CMP_W'(SETTLE);
   assign last_idx    = (idx == IDX_W'(N_MINTERMS - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx        <= '0;
         settle_cnt <= '0;
      end else if (clr) begin
         idx        <= '0;
         settle_cnt <= '0;
      end else if (adv) begin
         // idx saturates at the last minterm; the FSM ends the scan there
         if (!last_idx) idx <= idx + IDX_W'(1);
         settle_cnt <= '0;
      end else if (tick) begin
         settle_cnt <= settle_done ? '0 : settle_cnt + SETTLE_W'(1);
      end
   end

endmodule

// File: rtl/truth_table_scan.sv
// Steps a 4-input function through all minterms, captures its truth table,
// counts ones and compares against a golden table.
module truth_table_scan
   import truth_table_scan_pkg::*;
#(
   parameter int unsigned SETTLE = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  s,
   input  logic [N_MINTERMS-1:0] expected,
   output logic                  a,
   output logic                  b,
   output logic                  c,
   output logic                  d,
   output logic                  busy,
   output logic                  done,
   output logic [N_MINTERMS-1:0] truth_table,
   output logic [ONES_W-1:0]     ones,
   output logic                  match
);

   // With no settle time each minterm is sampled in the cycle it is driven
   localparam state_t FIRST = (SETTLE == 0) ? SAMPLE : WAIT;

   state_t           state;
   logic [IDX_W-1:0] idx;
   logic             settle_done;
   logic             last_idx;
   logic             clr_c;
   logic             adv_c;
   logic             tick_c;

   assign clr_c  = (state == IDLE) && start;
   assign adv_c  = (state == SAMPLE);
   assign tick_c = (state == WAIT);

   scan_counter #(
      .SETTLE (SETTLE)
   ) u_scan_counter (
      .clk         (clk),
      .rst_n       (rst_n),
      .clr         (clr_c),
      .adv         (adv_c),
      .tick        (tick_c),
      .idx         (idx),
      .settle_done (settle_done),
      .last_idx    (last_idx)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         {a, b, c, d} <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
         truth_table  <= '0;
         ones         <= '0;
         match        <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  state        <= FIRST;
                  {a, b, c, d} <= '0;
                  busy         <= 1'b1;
                  truth_table  <= '0;
                  ones         <= '0;
                  match        <= 1'b0;
               end
            end
            WAIT: begin
               if (settle_done) state <= SAMPLE;
            end
            SAMPLE: begin
               truth_table[idx] <= s;
               ones             <= ones + ONES_W'(s);
               if (last_idx) begin
                  state        <= DONE;
                  {a, b, c, d} <= '0;
                  busy         <= 1'b0;
                  done         <= 1'b1;
               end else begin
                  state        <= FIRST;
                  {a, b, c, d} <= idx + IDX_W'(1);
               end
            end
            DONE: begin
               // Golden table is only looked at here
               match <= (truth_table == expected);
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_truth_table_scan.sv
// Scoreboard bench: three scanners (SETTLE = 1, 0, 2) driven by directed scans.
module tb_truth_table_scan;

   typedef struct {
      int          k;
      logic [15:0] tbl;
      logic [4:0]  ones;
      logic        m;
      int          due;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [2:0]  start_v;
   logic [15:0] expected;
   logic        s1_const;
   logic        s0, s1, s2;
   logic [2:0]  a_v, b_v, c_v, d_v, busy_v, done_v, match_v;
   logic [15:0] tbl_v [3];
   logic [4:0]  ones_v [3];

   int   cyc = 0;
   int   nchk = 0;
   int   nfail = 0;
   exp_t q[$];

   bit         prev_busy [3];
   logic [3:0] prev_m [3];
   int         run [3];
   bit         pend [3];
   logic       pend_m [3];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic fn(input logic a, input logic b, input logic c, input logic d);
      return (~a & b & c & d) | (a & ~c & d) | (a & c & ~d) | (a & d & ~b);
   endfunction

   function automatic int settle_of(input int k);
      return (k == 0) ? 1 : (k == 1) ? 0 : 2;
   endfunction

   assign s0 = fn(a_v[0], b_v[0], c_v[0], d_v[0]);
   assign s1 = s1_const;
   assign s2 = fn(a_v[2], b_v[2], c_v[2], d_v[2]);

   truth_table_scan #(.SETTLE(1)) u_s1 (
      .clk(clk), .rst_n(rst_n), .start(start_v[0]), .s(s0), .expected(expected),
      .a(a_v[0]), .b(b_v[0]), .c(c_v[0]), .d(d_v[0]), .busy(busy_v[0]), .done(done_v[0]),
      .truth_table(tbl_v[0]), .ones(ones_v[0]), .match(match_v[0]));

   truth_table_scan #(.SETTLE(0)) u_s0 (
      .clk(clk), .rst_n(rst_n), .start(start_v[1]), .s(s1), .expected(expected),
      .a(a_v[1]), .b(b_v[1]), .c(c_v[1]), .d(d_v[1]), .busy(busy_v[1]), .done(done_v[1]),
      .truth_table(tbl_v[1]), .ones(ones_v[1]), .match(match_v[1]));

   truth_table_scan #(.SETTLE(2)) u_s2 (
      .clk(clk), .rst_n(rst_n), .start(start_v[2]), .s(s2), .expected(expected),
      .a(a_v[2]), .b(b_v[2]), .c(c_v[2]), .d(d_v[2]), .busy(busy_v[2]), .done(done_v[2]),
      .truth_table(tbl_v[2]), .ones(ones_v[2]), .match(match_v[2]));

   task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] req);
      nchk++;
      if (act !== req) begin
         nfail++;
         $display("FAIL %s inst%0d t=%0t actual=0x%0h required=0x%0h", name, k, $time, act, req);
      end
   endtask

   // Monitor: pops expectations on done and checks minterm sequencing every cycle
   always @(negedge clk) begin
      logic [3:0] m;
      exp_t       e;
      if (!rst_n) begin
         for (int k = 0; k < 3; k++) pend[k] = 1'b0;
      end else begin
         for (int k = 0; k < 3; k++) begin
            m = {a_v[k], b_v[k], c_v[k], d_v[k]};
            if (pend[k]) begin
               chk("match", k, 32'(match_v[k]), 32'(pend_m[k]));
               pend[k] = 1'b0;
            end
            if (done_v[k]) begin
               chk("done_expected", k, 32'(q.size() != 0 && q[0].k == k), 32'd1);
               if (q.size() != 0 && q[0].k == k) begin
                  e = q.pop_front();
                  chk("table", k, 32'(tbl_v[k]), 32'(e.tbl));
                  chk("ones", k, 32'(ones_v[k]), 32'(e.ones));
                  chk("latency", k, cyc, e.due);
                  chk("last_minterm", k, 32'(prev_m[k]), 32'd15);
                  chk("last_dwell", k, run[k], settle_of(k) + 1);
                  pend[k]   = 1'b1;
                  pend_m[k] = e.m;
               end
            end
            if (busy_v[k]) begin
               if (!prev_busy[k]) begin
                  chk("first_minterm", k, 32'(m), 32'd0);
                  run[k] = 1;
               end else if (m == prev_m[k]) begin
                  run[k]++;
               end else begin
                  chk("minterm_step", k, 32'(m), 32'(prev_m[k] + 4'd1));
                  chk("dwell", k, run[k], settle_of(k) + 1);
                  run[k] = 1;
               end
            end else begin
               chk("idle_inputs", k, 32'(m), 32'd0);
            end
            prev_busy[k] = busy_v[k];
            prev_m[k]    = m;
         end
      end
   end

   task automatic issue(input int k, input bit push, input logic [15:0] tbl,
                        input logic [4:0] ones, input logic m);
      exp_t e;
      @(negedge clk);
      start_v[k] = 1'b1;
      @(posedge clk);
      #1;
      if (push) begin
         e.k = k; e.tbl = tbl; e.ones = ones; e.m = m;
         e.due = cyc + 16 * (settle_of(k) + 1);
         q.push_back(e);
      end
      @(negedge clk);
      start_v[k] = 1'b0;
   endtask

   task automatic wait_empty();
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (q.size() == 0) break;
      end
      chk("scan_timeout", 0, 32'(q.size()), 32'd0);
      q.delete();
   endtask

   task automatic wait_minterm(input int k, input logic [3:0] target);
      logic [3:0] m;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         m = {a_v[k], b_v[k], c_v[k], d_v[k]};
         if (busy_v[k] && m == target) break;
      end
      chk("reach_minterm", k, 32'({a_v[k], b_v[k], c_v[k], d_v[k]}), 32'(target));
   endtask

   initial begin
      int base;
      rst_n    = 1'b0;
      start_v  = '0;
      expected = '0;
      s1_const = 1'b0;
      #7;
      for (int k = 0; k < 3; k++)
         chk("reset_state", k, {4'd0, tbl_v[k], ones_v[k], a_v[k], b_v[k], c_v[k], d_v[k],
                                busy_v[k], done_v[k], match_v[k]}, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Reference function, golden table matches
      expected = 16'h6E80;
      issue(0, 1'b1, 16'h6E80, 5'd6, 1'b1);
      wait_empty();
      repeat (3) @(negedge clk);

      // Golden table off by one bit
      expected = 16'h6E81;
      issue(0, 1'b1, 16'h6E80, 5'd6, 1'b0);
      wait_empty();
      repeat (3) @(negedge clk);

      // Constant-one and constant-zero functions, no settle time
      expected = 16'hFFFF;
      s1_const = 1'b1;
      issue(1, 1'b1, 16'hFFFF, 5'd16, 1'b1);
      wait_empty();
      repeat (3) @(negedge clk);
      s1_const = 1'b0;
      issue(1, 1'b1, 16'h0000, 5'd0, 1'b0);
      wait_empty();
      repeat (3) @(negedge clk);

      // Start re-pulsed mid-scan is ignored
      expected = 16'h6E80;
      issue(0, 1'b1, 16'h6E80, 5'd6, 1'b1);
      wait_minterm(0, 4'd5);
      start_v[0] = 1'b1;
      @(negedge clk);
      start_v[0] = 1'b0;
      wait_empty();
      repeat (40) @(negedge clk);

      // Reset mid-scan aborts with no done, then a fresh scan completes
      issue(0, 1'b0, 16'h0, 5'd0, 1'b0);
      wait_minterm(0, 4'd9);
      #2 rst_n = 1'b0;
      #1 chk("reset_abort", 0, {4'd0, tbl_v[0], ones_v[0], a_v[0], b_v[0], c_v[0], d_v[0],
                                busy_v[0], done_v[0], match_v[0]}, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
      chk("idle_after_reset", 0, 32'(busy_v[0]), 32'd0);
      issue(0, 1'b1, 16'h6E80, 5'd6, 1'b1);
      wait_empty();
      repeat (3) @(negedge clk);

      // Start held high: back-to-back scans with one idle cycle between
      @(negedge clk);
      start_v[2] = 1'b1;
      @(posedge clk);
      #1 base = cyc;
      for (int i = 0; i < 3; i++) begin
         exp_t e;
         e.k = 2; e.tbl = 16'h6E80; e.ones = 5'd6; e.m = 1'b1;
         e.due = base + 48 + i * 50;
         q.push_back(e);
      end
      wait_empty();
      start_v[2] = 1'b0;
      repeat (60) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
      $finish;
   end

endmodule
